// File: rtl/instruction_fetch.sv
// instruction_fetch
//
// Fetch stage front end: a PC register drives instruction memory
// combinationally and each fetched {pc, instruction} pair is queued in a
// small circular buffer that feeds the decode stage.
//
// Ports
//   clk              system clock; all state changes on the rising edge
//   reset            synchronous, active-high reset
//   enable           fetch permitted this cycle
//   redirect_valid   branch/jump redirect request (flushes the buffer)
//   redirect_pc      redirect target; the low two bits are ignored
//   imem_addr        address to instruction memory (equals the PC)
//   imem_instruction instruction memory data, combinational from imem_addr
//   out_valid        buffer head holds a valid entry
//   out_ready        decode stage accepts the head entry
//   out_pc           PC of the head entry
//   out_instruction  instruction of the head entry
//
// Handshake: an entry leaves the buffer on a rising edge where
// out_valid && out_ready && !redirect_valid. out_valid never depends on
// out_ready, and the head stays stable until it is popped, flushed or reset.
//
// DEPTH must be a power of two, at least 2.
module instruction_fetch #(
  parameter int WORDSIZE         = 64,
  parameter int INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC = '0,
  parameter int DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        redirect_valid,
  input  logic [WORDSIZE-1:0]         redirect_pc,
  output logic [WORDSIZE-1:0]         imem_addr,
  input  logic [INSTRUCTION_SIZE-1:0] imem_instruction,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORDSIZE-1:0]         out_pc,
  output logic [INSTRUCTION_SIZE-1:0] out_instruction
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WORDSIZE-1:0]         pc;
  logic [PTR_W-1:0]            head;
  logic [PTR_W-1:0]            tail;
  logic [CNT_W-1:0]            count;
  logic [WORDSIZE-1:0]         pc_mem    [DEPTH];
  logic [INSTRUCTION_SIZE-1:0] instr_mem [DEPTH];

  logic full;
  logic push;
  logic pop;

  // Full and push are judged on the count at the start of the cycle, so a
  // slot freed by a pop this cycle is only reusable on the next one.
  assign full      = (count == CNT_W'(DEPTH));
  assign push      = enable && !redirect_valid && !full;
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign imem_addr       = pc;
  assign out_valid       = (count != '0);
  assign out_pc          = pc_mem[head];
  assign out_instruction = instr_mem[head];

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Flush everything; the target is word aligned by masking its low bits.
      pc    <= redirect_pc & ~WORDSIZE'(3);
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[tail]    <= pc;
        instr_mem[tail] <= imem_instruction;
        tail            <= tail + 1'b1;
        pc              <= pc + WORDSIZE'(4);
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch (default parameters).
// Instruction memory is modelled as a pure function of the address so every
// expected instruction can be recomputed from an expected PC.
module tb_instruction_fetch;

  localparam int W = 64;
  localparam int I = 32;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          redirect_valid;
  logic [W-1:0]  redirect_pc;
  logic [W-1:0]  imem_addr;
  logic [I-1:0]  imem_instruction;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_pc;
  logic [I-1:0]  out_instruction;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .imem_addr        (imem_addr),
    .imem_instruction (imem_instruction),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_pc           (out_pc),
    .out_instruction  (out_instruction)
  );

  function automatic logic [I-1:0] mem_word(input logic [W-1:0] a);
    return a[31:0] ^ 32'hA5A5_0013;
  endfunction

  assign imem_instruction = mem_word(imem_addr);

  // ---------------- driver tasks ----------------
  // Advance one rising edge, then let outputs settle before anything is
  // sampled or driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_head(input string tag, input logic [W-1:0] exp_pc);
    check({tag, ".valid"}, W'(out_valid), W'(1));
    check({tag, ".pc"}, out_pc, exp_pc);
    check({tag, ".instr"}, W'(out_instruction), W'(mem_word(exp_pc)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    enable = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst.valid", W'(out_valid), W'(0));
    check("rst.pc", out_pc, W'(0));
    check("rst.instr", W'(out_instruction), W'(0));
    check("rst.addr", imem_addr, W'(0));
    check("rst.count", W'(dut.count), W'(0));

    // Streaming: one entry per cycle, 1-cycle latency
    enable = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_head($sformatf("stream%0d", i), W'(i * 4));
      check($sformatf("stream%0d.count", i), W'(dut.count), W'(1));
    end

    // Backpressure from a fresh reset
    do_reset();
    enable = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("bp.count", W'(dut.count), W'(4));
    check("bp.addr", imem_addr, W'(16));
    check_head("bp.head", W'(0));

    // Drain with enable on: 4 -> 3, then steady at 3 with push+pop
    out_ready = 1'b1;
    tick();
    check_head("drain0", W'(4));
    check("drain0.count", W'(dut.count), W'(3));
    check("drain0.addr", imem_addr, W'(16));
    tick();
    check_head("drain1", W'(8));
    check("drain1.count", W'(dut.count), W'(3));
    tick();
    check_head("drain2", W'(12));
    check("drain2.count", W'(dut.count), W'(3));
    tick();
    check_head("drain3", W'(16));
    check("drain3.count", W'(dut.count), W'(3));
    check("drain3.addr", imem_addr, W'(28));

    // enable=0: buffered entries still pop, PC holds
    enable = 1'b0;
    tick();
    check_head("en0a", W'(20));
    check("en0a.count", W'(dut.count), W'(2));
    tick();
    check_head("en0b", W'(24));
    tick();
    check("en0c.valid", W'(out_valid), W'(0));
    check("en0c.addr", imem_addr, W'(28));

    // Redirect while full
    enable = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("refill.count", W'(dut.count), W'(4));
    redirect_valid = 1'b1;
    redirect_pc = W'(32'h1003);
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check("redir.valid", W'(out_valid), W'(0));
    check("redir.addr", imem_addr, W'(32'h1000));
    check("redir.count", W'(dut.count), W'(0));
    tick();
    check_head("redir.head", W'(32'h1000));

    // Reset mid-stream with count=3 and a competing redirect
    out_ready = 1'b0;
    tick();
    tick();
    check("mid.count3", W'(dut.count), W'(3));
    redirect_valid = 1'b1;
    redirect_pc = W'(32'h2000);
    do_reset();
    redirect_valid = 1'b0;
    check("mid.valid", W'(out_valid), W'(0));
    check("mid.count", W'(dut.count), W'(0));
    check("mid.addr", imem_addr, W'(0));

    // Wrap-around at the top of the address space
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    check("wrap.addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap.valid0", W'(out_valid), W'(0));
    tick();
    check_head("wrap.top", 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap.addr0", imem_addr, W'(0));
    tick();
    check_head("wrap.zero", W'(0));

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
